// File: rtl/audio_codec_master.sv
// audio_codec_master: master end of a left-justified audio serial link.
// Generates BCLK and the LR clocks, serialises ADC sample pairs onto
// AUD_ADCDAT and deserialises AUD_DACDAT back into parallel pairs.
// Optional build macro AUDIO_CODEC_HOLD_LAST_EN: when defined, an underrun
// frame repeats the previously transmitted pair instead of sending zeros.
module audio_codec_master #(
  parameter int DATA_WIDTH       = 32,
  parameter int BCLK_HALF_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] adc_left,
  input  logic [DATA_WIDTH-1:0] adc_right,
  input  logic                  adc_valid,
  output logic                  adc_ready,
  output logic [DATA_WIDTH-1:0] dac_left,
  output logic [DATA_WIDTH-1:0] dac_right,
  output logic                  dac_valid,
  output logic                  underrun,
  output logic                  AUD_BCLK,
  output logic                  AUD_ADCLRCK,
  output logic                  AUD_DACLRCK,
  output logic                  AUD_ADCDAT,
  input  logic                  AUD_DACDAT
);

  localparam int DIV_W = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick, rise, fall, frame_start, go_idle;

  logic                  bclk_q, lrck_q, adcdat_q;
  logic [IDX_W-1:0]      bit_q;
  logic [IDX_W-1:0]      bit_dec;
  logic                  full_q;
  logic                  dac_valid_q, underrun_q;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_r_q;
  logic [DATA_WIDTH-1:0] tx_l_q, tx_r_q;
  logic [DATA_WIDTH-1:0] cap_l_q, cap_r_q;
  logic [DATA_WIDTH-1:0] dac_l_q, dac_r_q;
  logic [DATA_WIDTH-1:0] load_l, load_r;
  logic [DATA_WIDTH-1:0] fill_l, fill_r;
  logic                  accept;

  assign accept  = adc_valid && !full_q;
  assign bit_dec = bit_q - IDX_W'(1);

  // Pair sent when a frame starts with nothing held.
`ifdef AUDIO_CODEC_HOLD_LAST_EN
  assign fill_l = tx_l_q;
  assign fill_r = tx_r_q;
`else
  assign fill_l = '0;
  assign fill_r = '0;
`endif

  assign load_l = full_q ? hold_l_q : fill_l;
  assign load_r = full_q ? hold_r_q : fill_r;

  // State and divider registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  // Next state, divider and tick decode; the BCLK level selects rise or fall.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tick        = (div_q == DIV_MAX);
    rise        = 1'b0;
    fall        = 1'b0;
    frame_start = 1'b0;
    go_idle     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!enable) begin
          div_d = '0;
        end else if (tick) begin
          div_d       = '0;
          frame_start = 1'b1;
          state_d     = S_RUN;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_RUN: begin
        if (tick) begin
          div_d = '0;
          if (!bclk_q) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            // Right-channel LSB just finished: either start a new frame or stop.
            if (!lrck_q && bit_q == '0) begin
              if (enable) begin
                frame_start = 1'b1;
              end else begin
                go_idle = 1'b1;
                state_d = S_IDLE;
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serial framing, holding-register flag, DAC output words and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      adcdat_q    <= 1'b0;
      bit_q       <= IDX_MSB;
      full_q      <= 1'b0;
      dac_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      dac_l_q     <= '0;
      dac_r_q     <= '0;
    end else begin
      dac_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      if (accept) full_q <= 1'b1;
      if (rise) begin
        bclk_q <= 1'b1;
        if (!lrck_q && bit_q == '0) begin
          dac_l_q     <= cap_l_q;
          dac_r_q     <= {cap_r_q[DATA_WIDTH-2:0], AUD_DACDAT};
          dac_valid_q <= 1'b1;
        end
      end
      if (fall) begin
        bclk_q <= 1'b0;
        if (bit_q != '0) begin
          bit_q    <= bit_dec;
          adcdat_q <= lrck_q ? tx_l_q[bit_dec] : tx_r_q[bit_dec];
        end else if (lrck_q) begin
          lrck_q   <= 1'b0;
          bit_q    <= IDX_MSB;
          adcdat_q <= tx_r_q[DATA_WIDTH-1];
        end
      end
      // A same-cycle accept into an empty register is not used by this frame.
      if (frame_start) begin
        lrck_q   <= 1'b1;
        bit_q    <= IDX_MSB;
        tx_l_q   <= load_l;
        tx_r_q   <= load_r;
        adcdat_q <= load_l[DATA_WIDTH-1];
        if (full_q) full_q     <= 1'b0;
        else        underrun_q <= 1'b1;
      end
      if (go_idle) begin
        bclk_q   <= 1'b0;
        lrck_q   <= 1'b0;
        adcdat_q <= 1'b0;
        bit_q    <= IDX_MSB;
      end
    end
  end

  // Holding-register data, written on every accepted transfer.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_l_q <= adc_left;
      hold_r_q <= adc_right;
    end
  end

  // DAC capture shift registers, filled MSB first on BCLK rise ticks.
  always_ff @(posedge clk) begin
    if (rise) begin
      if (lrck_q) cap_l_q <= {cap_l_q[DATA_WIDTH-2:0], AUD_DACDAT};
      else        cap_r_q <= {cap_r_q[DATA_WIDTH-2:0], AUD_DACDAT};
    end
  end

  assign adc_ready   = !full_q;
  assign dac_left    = dac_l_q;
  assign dac_right   = dac_r_q;
  assign dac_valid   = dac_valid_q;
  assign underrun    = underrun_q;
  assign AUD_BCLK    = bclk_q;
  assign AUD_ADCLRCK = lrck_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_ADCDAT  = adcdat_q;

endmodule

// File: tb/tb_audio_codec_master.sv
// Testbench for audio_codec_master: directed steps with a frame scoreboard.
module tb_audio_codec_master;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [DW-1:0] adc_left, adc_right;
  logic          adc_valid;
  logic          adc_ready;
  logic [DW-1:0] dac_left, dac_right;
  logic          dac_valid, underrun;
  logic          AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT;
  logic          AUD_DACDAT;
  logic          loop_en;

  audio_codec_master #(.DATA_WIDTH(DW), .BCLK_HALF_PERIOD(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid),
    .adc_ready(adc_ready), .dac_left(dac_left), .dac_right(dac_right),
    .dac_valid(dac_valid), .underrun(underrun),
    .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_ADCDAT(AUD_ADCDAT), .AUD_DACDAT(AUD_DACDAT)
  );

  assign AUD_DACDAT = loop_en ? AUD_ADCDAT : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_dv     = 0;
  int n_under  = 0;
  int cyc      = 0;
  int last_dv  = -1;

  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] dac_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: rebuilds ADC words at BCLK rises and checks DAC output pairs.
  logic [DW-1:0]   acc_l, acc_r;
  int              nl, nr;
  logic            prev_bclk;
  logic [2*DW-1:0] e_mon;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      acc_l = '0; acc_r = '0; nl = 0; nr = 0; prev_bclk = 1'b0; last_dv = -1;
    end else begin
      if (AUD_BCLK && !prev_bclk) begin
        chk("lrck_match", AUD_DACLRCK, AUD_ADCLRCK);
        if (AUD_ADCLRCK) begin
          acc_l = {acc_l[DW-2:0], AUD_ADCDAT};
          nl++;
        end else begin
          acc_r = {acc_r[DW-2:0], AUD_ADCDAT};
          nr++;
          if (nr == DW) begin
            chk("left_bit_count", nl, DW);
            n_assert++;
            assert (exp_q.size() != 0) else begin
              n_fail++;
              $error("FAIL unexpected_frame: observed %0h expected none", {acc_l, acc_r});
            end
            if (exp_q.size() != 0) begin
              e_mon = exp_q.pop_front();
              chk("adc_frame", {acc_l, acc_r}, e_mon);
            end
            nl = 0; nr = 0;
          end
        end
      end
      prev_bclk = AUD_BCLK;
      if (dac_valid) begin
        n_dv++;
        n_assert++;
        assert (dac_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_dac_valid: observed %0h expected none", {dac_left, dac_right});
        end
        if (dac_q.size() != 0) begin
          e_mon = dac_q.pop_front();
          chk("dac_pair", {dac_left, dac_right}, e_mon);
        end
        if (last_dv >= 0) chk("dac_interval", cyc - last_dv, 512);
        last_dv = cyc;
      end
      if (underrun) n_under++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
    chk("ready_before_offer", adc_ready, 1'b1);
    adc_left = l; adc_right = r; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    chk("ready_after_accept", adc_ready, 1'b0);
  endtask

  task automatic push_frame(input logic [2*DW-1:0] f);
    exp_q.push_back(f);
    dac_q.push_back(f);
  endtask

  task automatic wait_lrck_rise(input string tag);
    logic prev;
    logic found;
    prev  = AUD_ADCLRCK;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (AUD_ADCLRCK && !prev) begin
        found = 1'b1;
        break;
      end
      prev = AUD_ADCLRCK;
    end
    chk(tag, found, 1'b1);
  endtask

  logic [2*DW-1:0] pa, pb, pc, und;
  int cnt, dv_snap, un_snap;
  logic found_fall;

  initial begin
    pa = {32'h8000_0001, 32'h7FFF_FFFE};
    pb = {32'h1234_5678, 32'h9ABC_DEF0};
    pc = {32'hA5A5_0F0F, 32'h0123_4567};
`ifdef AUDIO_CODEC_HOLD_LAST_EN
    und = pa;
`else
    und = '0;
`endif
    reset = 1'b1; enable = 1'b0; adc_valid = 1'b0;
    adc_left = '0; adc_right = '0; loop_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_bclk", AUD_BCLK, 1'b0);
    chk("rst_adclrck", AUD_ADCLRCK, 1'b0);
    chk("rst_daclrck", AUD_DACLRCK, 1'b0);
    chk("rst_adcdat", AUD_ADCDAT, 1'b0);
    chk("rst_dac_valid", dac_valid, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_dac_left", dac_left, 32'h0);
    chk("rst_dac_right", dac_right, 32'h0);
    chk("rst_adc_ready", adc_ready, 1'b1);
    reset = 1'b0;

    // Idle with enable low
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outputs", {AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT, dac_valid, underrun}, 6'b0);
      chk("idle_ready", adc_ready, 1'b1);
    end

    // Single transmit: frame 1 carries pa
    offer(pa[63:32], pa[31:0]);
    push_frame(pa);
    enable = 1'b1;
    wait_lrck_rise("frame1_start");
    chk("frame1_no_underrun", underrun, 1'b0);
    chk("frame1_ready_back", adc_ready, 1'b1);
    cnt = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (AUD_ADCLRCK) cnt++; else break;
    end
    chk("lrck_high_cycles", cnt, 256);
    cnt = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!AUD_ADCLRCK) cnt++; else break;
    end
    chk("lrck_low_cycles", cnt, 256);

    // Frame 2: nothing held, underrun
    chk("frame2_underrun", underrun, 1'b1);
    push_frame(und);

    // Frame 3: offer lands on the frame-start edge
    repeat (511) @(negedge clk);
    chk("pre_frame3_lrck", AUD_ADCLRCK, 1'b0);
    adc_left = pb[63:32]; adc_right = pb[31:0]; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    chk("frame3_lrck", AUD_ADCLRCK, 1'b1);
    chk("frame3_underrun", underrun, 1'b1);
    chk("frame3_ready", adc_ready, 1'b0);
    push_frame(und);
    push_frame(pb);

    // Frame 4: pb sent from the held register
    wait_lrck_rise("frame4_start");
    chk("frame4_no_underrun", underrun, 1'b0);
    chk("frame4_ready_back", adc_ready, 1'b1);
    offer(pc[63:32], pc[31:0]);
    push_frame(pc);

    // Frame 5: enable dropped mid-frame, frame completes then idles
    wait_lrck_rise("frame5_start");
    chk("frame5_no_underrun", underrun, 1'b0);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    found_fall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!AUD_ADCLRCK) begin
        found_fall = 1'b1;
        break;
      end
    end
    chk("frame5_lrck_fall", found_fall, 1'b1);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (AUD_ADCLRCK) cnt++;
    end
    chk("stopped_lrck_high_count", cnt, 0);
    chk("stopped_bclk", AUD_BCLK, 1'b0);
    chk("stopped_adcdat", AUD_ADCDAT, 1'b0);
    chk("frames_left", exp_q.size(), 0);
    chk("dac_left_pending", dac_q.size(), 0);
    chk("dac_valid_count", n_dv, 5);
    chk("underrun_count", n_under, 2);
    chk("last_dac_left", dac_left, pc[63:32]);
    chk("last_dac_right", dac_right, pc[31:0]);

    // Reset around left bit 10
    offer(32'hDEAD_BEEF, 32'h0BAD_F00D);
    enable = 1'b1;
    wait_lrck_rise("frame6_start");
    repeat (170) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT, dac_valid, underrun}, 6'b0);
    chk("midrst_dac_left", dac_left, 32'h0);
    chk("midrst_dac_right", dac_right, 32'h0);
    chk("midrst_ready", adc_ready, 1'b1);
    exp_q.delete();
    dac_q.delete();
    reset = 1'b0;
    dv_snap = n_dv;
    un_snap = n_under;
    repeat (600) @(negedge clk);
    chk("postrst_no_dac_valid", n_dv, dv_snap);
    chk("postrst_no_underrun", n_under, un_snap);
    chk("postrst_bclk", AUD_BCLK, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
